// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared constants, tag type and round-robin pick for adder scheduling
package adder_sched_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NREQ_DEF = 4;
  localparam int LAT_DEF = 2;
  localparam int NREQ_MAX = 16;
  localparam int IDW_MAX = 4;
  localparam int PW = IDW_MAX + 1;
  typedef struct packed {
    logic vld;
    logic [IDW_MAX-1:0] id;
  } tag_t;
  function automatic logic [IDW_MAX:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                               input logic [IDW_MAX-1:0] ptr, input int n);
    logic [IDW_MAX:0] r;
    logic [IDW_MAX:0] j;
    r = '0;
    // walk downward so the candidate closest to ptr is written last and wins
    for (int k = NREQ_MAX - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + PW'(k);
      if (j >= PW'(n)) j = j - PW'(n);
      if (k < n && req[j[IDW_MAX-1:0]]) r = {1'b1, j[IDW_MAX-1:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/adder_rr_share_ctrl_arbiter.sv
// rr_arbiter: combinational round-robin arbiter returning one-hot grant and its index
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IDW_MAX:0] pick;
  always_comb begin
    pick = rr_pick(NREQ_MAX'(req), IDW_MAX'(ptr), N);
    idx = IW'(pick[IDW_MAX-1:0]);
    gnt = (en && pick[IDW_MAX]) ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/adder_rr_share_ctrl.sv
// adder_rr_share_ctrl: round-robin sharing of one pipelined adder among NREQ requesters
module adder_rr_share_ctrl
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = LAT_DEF,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_en,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  input  logic [WIDTH-1:0]          add_sum,
  input  logic                      add_cout,
  output logic [NREQ-1:0]           resp_valid,
  output logic [WIDTH-1:0]          resp_sum,
  output logic                      resp_cout,
  output logic [$clog2(LAT+2)-1:0]  inflight,
  output logic [31:0]               op_count
);
  localparam int FW = $clog2(LAT + 2);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] idx, rr_ptr;
  logic xfer;
  logic [WIDTH-1:0] last_a, last_b;
  tag_t pipe [LAT];
  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en (issue_en & ~rst),
    .gnt(gnt),
    .idx(idx)
  );
  // operands hold their last issued value while idle so the adder does not toggle
  always_comb begin
    req_ready = gnt;
    xfer = |(req_valid & gnt);
    add_a = xfer ? req_a[idx*WIDTH +: WIDTH] : last_a;
    add_b = xfer ? req_b[idx*WIDTH +: WIDTH] : last_b;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      last_a <= '0;
      last_b <= '0;
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
      resp_valid <= '0;
      resp_sum <= '0;
      resp_cout <= 1'b0;
      inflight <= '0;
      op_count <= '0;
    end else begin
      if (xfer) begin
        rr_ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        last_a <= add_a;
        last_b <= add_b;
      end
      pipe[0] <= {xfer, IDW_MAX'(idx)};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      resp_valid <= pipe[LAT-1].vld ? NREQ'(1) << pipe[LAT-1].id : '0;
      if (pipe[LAT-1].vld) begin
        resp_sum <= add_sum;
        resp_cout <= add_cout;
      end
      inflight <= inflight + FW'(xfer) - FW'(|resp_valid);
      if (xfer && op_count != '1) op_count <= op_count + 1'b1;
    end
  end
endmodule
